// File: rtl/issue_hazard_ctrl.sv
// Dual-issue hazard scheduler: per-register countdown scoreboard that gates issue
// so every dependent finds its producer within reach of the forwarding network.
module issue_hazard_ctrl #(
   parameter int REG_NUM = 32,
   parameter int LAT_W   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              issue_valid_i,
   input  logic [1:0][1:0][4:0]    rs_i,
   input  logic [1:0][4:0]         rd_i,
   input  logic [1:0][LAT_W-1:0]   lat_i,
   input  logic                    pipe_advance_i,
   input  logic                    flush_i,
   output logic [1:0]              issue_grant_o,
   output logic                    stall_o,
   output logic [REG_NUM-1:0]      busy_o
);

   logic [LAT_W-1:0] cnt [REG_NUM];
   logic [3:0]       src_rdy;
   logic             raw1;

   always_comb begin
      src_rdy = '0;
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 2; k++) begin
            // cnt[0] is held at zero, so a zero index always reads as ready
            src_rdy[2*s+k] = (cnt[rs_i[s][k]] == '0);
         end
      end

      raw1 = ((rs_i[1][0] != 5'd0) && (rs_i[1][0] == rd_i[0])) ||
             ((rs_i[1][1] != 5'd0) && (rs_i[1][1] == rd_i[0]));

      issue_grant_o    = '0;
      issue_grant_o[0] = issue_valid_i[0] && pipe_advance_i && !flush_i &&
                         src_rdy[0] && src_rdy[1];
      issue_grant_o[1] = issue_grant_o[0] && issue_valid_i[1] &&
                         src_rdy[2] && src_rdy[3] && !raw1;

      stall_o = (issue_valid_i[0] && !issue_grant_o[0]) ||
                (issue_valid_i[1] && !issue_grant_o[1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < REG_NUM; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < REG_NUM; r++) begin
            if (flush_i) begin
               cnt[r] <= '0;
            end else if (issue_grant_o[1] && (rd_i[1] == 5'(r))) begin
               // younger slot wins a same-bundle WAW
               cnt[r] <= lat_i[1];
            end else if (issue_grant_o[0] && (rd_i[0] == 5'(r))) begin
               cnt[r] <= lat_i[0];
            end else if (pipe_advance_i && (cnt[r] != '0)) begin
               cnt[r] <= cnt[r] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      busy_o = '0;
      for (int r = 0; r < REG_NUM; r++) begin
         busy_o[r] = (cnt[r] != '0);
      end
   end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Bench for issue_hazard_ctrl: directed scenarios plus randomized traffic checked
// against a model that tracks, per register, the backend-advance count at which it becomes ready.
module tb_issue_hazard_ctrl;

   logic                 clk;
   logic                 rst_n;
   logic [1:0]           issue_valid;
   logic [1:0][1:0][4:0] rs;
   logic [1:0][4:0]      rd;
   logic [1:0][1:0]      lat;
   logic                 pipe_advance;
   logic                 flush;
   logic [1:0]           issue_grant;
   logic                 stall;
   logic [31:0]          busy;

   int checks   = 0;
   int failures = 0;

   // model: ready_at[r] = number of backend advances after which r is sourceable
   int adv_total;
   int ready_at [32];

   issue_hazard_ctrl #(.REG_NUM(32), .LAT_W(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .issue_valid_i  (issue_valid),
      .rs_i           (rs),
      .rd_i           (rd),
      .lat_i          (lat),
      .pipe_advance_i (pipe_advance),
      .flush_i        (flush),
      .issue_grant_o  (issue_grant),
      .stall_o        (stall),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_ready(input logic [4:0] r);
      return (r == 5'd0) || (adv_total >= ready_at[r]);
   endfunction

   function automatic logic [1:0] m_grant();
      logic [1:0] g;
      g = 2'b00;
      if (issue_valid[0] && pipe_advance && !flush && m_ready(rs[0][0]) && m_ready(rs[0][1]))
         g[0] = 1'b1;
      if (g[0] && issue_valid[1] && m_ready(rs[1][0]) && m_ready(rs[1][1]) &&
          !(rs[1][0] != 0 && rs[1][0] == rd[0]) && !(rs[1][1] != 0 && rs[1][1] == rd[0]))
         g[1] = 1'b1;
      return g;
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b;
      b = '0;
      for (int r = 1; r < 32; r++) b[r] = (adv_total < ready_at[r]);
      return b;
   endfunction

   task automatic m_clear();
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
   endtask

   task automatic drive(input logic [1:0] v,
                        input logic [4:0] a0, input logic [4:0] b0, input logic [4:0] d0, input logic [1:0] l0,
                        input logic [4:0] a1, input logic [4:0] b1, input logic [4:0] d1, input logic [1:0] l1,
                        input logic adv, input logic fl);
      issue_valid = v;
      rs[0][0] = a0; rs[0][1] = b0; rd[0] = d0; lat[0] = l0;
      rs[1][0] = a1; rs[1][1] = b1; rd[1] = d1; lat[1] = l1;
      pipe_advance = adv;
      flush = fl;
      #1;
   endtask

   // advance the model by one cycle using the current inputs, then clock the DUT
   task automatic tick();
      logic [1:0] g;
      int a;
      g = m_grant();
      a = adv_total;
      if (flush) begin
         m_clear();
      end else begin
         if (g[0] && rd[0] != 0) ready_at[rd[0]] = a + 1 + int'(lat[0]);
         if (g[1] && rd[1] != 0) ready_at[rd[1]] = a + 1 + int'(lat[1]);
      end
      if (pipe_advance) adv_total++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(2'b00, 0,0,0,0, 0,0,0,0, 1'b1, 1'b0);
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(2'b00, 0,0,0,0, 0,0,0,0, 1'b0, 1'b0);
      adv_total = 0;
      m_clear();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checks++;
      if (busy !== 32'h0) begin
         failures++;
         $display("FAIL reset_busy got=%h exp=%h", busy, 32'h0);
      end
      drive(2'b11, 1,2,3,3, 4,5,6,3, 1'b1, 1'b0);
      checks++;
      if (issue_grant !== 2'b11) begin
         failures++;
         $display("FAIL reset_grant got=%b exp=%b", issue_grant, 2'b11);
      end
      drive(2'b00, 0,0,0,0, 0,0,0,0, 1'b1, 1'b0);
   endtask

   task automatic test_basic();
      idle(4);
      drive(2'b11, 3,4,5,0, 6,0,7,0, 1'b1, 1'b0);
      checks++;
      if (issue_grant !== 2'b11 || stall !== 1'b0) begin
         failures++;
         $display("FAIL basic_grant got=%b/%b exp=11/0", issue_grant, stall);
      end
      tick();
      checks++;
      if (busy !== 32'h0) begin
         failures++;
         $display("FAIL basic_busy got=%h exp=0", busy);
      end
   endtask

   task automatic test_load_use();
      idle(4);
      drive(2'b01, 0,0,5,2, 0,0,0,0, 1'b1, 1'b0);
      checks++;
      if (issue_grant !== 2'b01) begin
         failures++;
         $display("FAIL load_issue got=%b exp=01", issue_grant);
      end
      tick();
      for (int t = 1; t <= 3; t++) begin
         drive(2'b01, 5,0,0,0, 0,0,0,0, 1'b1, 1'b0);
         checks++;
         if (issue_grant !== ((t == 3) ? 2'b01 : 2'b00) || busy[5] !== (t != 3)) begin
            failures++;
            $display("FAIL load_use_t%0d got=%b busy5=%b exp=%b busy5=%b", t, issue_grant, busy[5],
                     (t == 3) ? 2'b01 : 2'b00, (t != 3));
         end
         tick();
      end
   endtask

   task automatic test_raw();
      idle(4);
      drive(2'b11, 0,0,8,0, 8,0,0,0, 1'b1, 1'b0);
      checks++;
      if (issue_grant !== 2'b01 || stall !== 1'b1) begin
         failures++;
         $display("FAIL raw_block got=%b/%b exp=01/1", issue_grant, stall);
      end
      tick();
      drive(2'b11, 0,0,0,1, 0,0,0,1, 1'b1, 1'b0);
      checks++;
      if (issue_grant !== 2'b11) begin
         failures++;
         $display("FAIL raw_zero got=%b exp=11", issue_grant);
      end
      tick();
   endtask

   task automatic test_backend_stall();
      idle(4);
      drive(2'b01, 0,0,12,2, 0,0,0,0, 1'b1, 1'b0);
      tick();
      for (int t = 1; t <= 5; t++) begin
         drive(2'b01, 12,0,0,0, 0,0,0,0, (t >= 3), 1'b0);
         checks++;
         if (issue_grant !== ((t == 5) ? 2'b01 : 2'b00) || stall !== (t != 5) || busy[12] !== (t != 5)) begin
            failures++;
            $display("FAIL bstall_t%0d got=%b/%b busy12=%b exp=%b/%b busy12=%b", t, issue_grant, stall,
                     busy[12], (t == 5) ? 2'b01 : 2'b00, (t != 5), (t != 5));
         end
         tick();
      end
   endtask

   task automatic test_waw_flush();
      idle(4);
      drive(2'b11, 0,0,9,0, 0,0,9,3, 1'b1, 1'b0);
      tick();
      checks++;
      if (busy[9] !== 1'b1) begin
         failures++;
         $display("FAIL waw_busy got=%b exp=1", busy[9]);
      end
      drive(2'b01, 0,0,0,0, 0,0,0,0, 1'b1, 1'b1);
      checks++;
      if (issue_grant !== 2'b00) begin
         failures++;
         $display("FAIL flush_grant got=%b exp=00", issue_grant);
      end
      tick();
      drive(2'b01, 9,0,0,0, 0,0,0,0, 1'b1, 1'b0);
      checks++;
      if (busy !== 32'h0 || issue_grant !== 2'b01) begin
         failures++;
         $display("FAIL flush_clear got=%h/%b exp=0/01", busy, issue_grant);
      end
      tick();
      drive(2'b01, 0,0,9,3, 0,0,0,0, 1'b1, 1'b0);
      tick();
      drive(2'b00, 0,0,0,0, 0,0,0,0, 1'b0, 1'b1);
      tick();
      checks++;
      if (busy !== 32'h0) begin
         failures++;
         $display("FAIL flush_noadv got=%h exp=0", busy);
      end
   endtask

   task automatic test_older_block();
      idle(4);
      drive(2'b01, 0,0,10,3, 0,0,0,0, 1'b1, 1'b0);
      tick();
      drive(2'b11, 10,0,0,0, 1,2,3,0, 1'b1, 1'b0);
      checks++;
      if (issue_grant !== 2'b00 || stall !== 1'b1) begin
         failures++;
         $display("FAIL older_block got=%b/%b exp=00/1", issue_grant, stall);
      end
      tick();
   endtask

   task automatic test_random();
      logic [1:0] eg;
      logic       es;
      idle(4);
      for (int i = 0; i < 3000; i++) begin
         drive(2'($urandom_range(0, 3)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 9) < 8), ($urandom_range(0, 29) == 0));
         eg = m_grant();
         es = (issue_valid[0] && !eg[0]) || (issue_valid[1] && !eg[1]);
         checks++;
         if (issue_grant !== eg || stall !== es) begin
            failures++;
            $display("FAIL rand_grant i=%0d got=%b/%b exp=%b/%b", i, issue_grant, stall, eg, es);
         end
         tick();
         checks++;
         if (busy !== m_busy()) begin
            failures++;
            $display("FAIL rand_busy i=%0d got=%h exp=%h", i, busy, m_busy());
         end
      end
   endtask

   task automatic test_reset_midop();
      idle(4);
      drive(2'b11, 0,0,11,3, 0,0,13,2, 1'b1, 1'b0);
      tick();
      drive(2'b01, 11,0,0,0, 0,0,0,0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      m_clear();
      checks++;
      if (busy !== 32'h0 || issue_grant !== 2'b01) begin
         failures++;
         $display("FAIL reset_midop got=%h/%b exp=0/01", busy, issue_grant);
      end
      drive(2'b00, 0,0,0,0, 0,0,0,0, 1'b1, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(2'b01, 13,11,0,0, 0,0,0,0, 1'b1, 1'b0);
      checks++;
      if (issue_grant !== 2'b01) begin
         failures++;
         $display("FAIL reset_release got=%b exp=01", issue_grant);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_load_use();
      test_raw();
      test_backend_stall();
      test_waw_flush();
      test_older_block();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
